// File: rtl/noc_params.sv
// Network-on-chip shared parameters: router radix, virtual channels per port and port encoding.
package noc_params;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = $clog2(VC_NUM);

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer,
// pointer moves one past the winner when update_i is set and a grant was made.
module round_robin_arbiter #(
  parameter int AGENTS_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AGENTS_NUM-1:0] requests_i,
  input  logic                  update_i,
  output logic [AGENTS_NUM-1:0] grants_o
);

  localparam int PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grants_o = '0;
    win      = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < AGENTS_NUM; i++) begin
      // cyclic scan starting at ptr, without a modulo operator
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(AGENTS_NUM)) sum = sum - (PTR_W+1)'(AGENTS_NUM);
      idx = sum[PTR_W-1:0];
      if (!found && requests_i[idx]) begin
        grants_o[idx] = 1'b1;
        win           = idx;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (update_i && found)
      ptr <= ({1'b0, win} == (PTR_W+1)'(AGENTS_NUM-1)) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration, then per-output port arbitration.
// Define SA_ON_OFF_GATING_EN to mask requests whose downstream VC is flow-controlled off.
module switch_allocator
  import noc_params::*;
#(
  parameter int AGENTS_PTR_SIZE = $clog2(PORT_NUM)
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]                    request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]                    out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]       downstream_vc_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]                    on_off_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]                    read_o,
  output logic  [PORT_NUM-1:0][AGENTS_PTR_SIZE-1:0]           xbar_sel_o,
  output logic  [PORT_NUM-1:0]                                valid_o
);

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   s1_gnt;
  logic  [PORT_NUM-1:0]               s1_valid;
  port_t [PORT_NUM-1:0]               s1_port;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;   // [output][input]
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_gnt;   // [output][input]
  logic  [PORT_NUM-1:0]               in_won;
  logic  [PORT_NUM-1:0]               out_gnt;
  logic  [PORT_NUM-1:0][AGENTS_PTR_SIZE-1:0] sel_nxt;

`ifdef SA_ON_OFF_GATING_EN
  always_comb begin
    eligible = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        eligible[p][v] = request_i[p][v] & on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]];
  end
`else
  logic unused_flow_ctrl;
  assign unused_flow_ctrl = ^{on_off_i, downstream_vc_i};
  assign eligible = request_i;
`endif

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in_arb
    // a port's VC pointer only moves once its offer survives output arbitration
    round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_in_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .requests_i (eligible[p]),
      .update_i   (in_won[p]),
      .grants_o   (s1_gnt[p])
    );
  end

  always_comb begin
    s1_valid = '0;
    s1_port  = {PORT_NUM{LOCAL}};
    s2_req   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      s1_valid[p] = |s1_gnt[p];
      for (int v = 0; v < VC_NUM; v++)
        if (s1_gnt[p][v]) s1_port[p] = out_port_i[p][v];
    end
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        s2_req[o][p] = s1_valid[p] && (int'(s1_port[p]) == o);
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
    round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_out_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .requests_i (s2_req[o]),
      .update_i   (|s2_req[o]),
      .grants_o   (s2_gnt[o])
    );
  end

  always_comb begin
    in_won  = '0;
    out_gnt = '0;
    sel_nxt = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      out_gnt[o] = |s2_gnt[o];
      for (int p = 0; p < PORT_NUM; p++)
        if (s2_gnt[o][p]) begin
          in_won[p]  = 1'b1;
          sel_nxt[o] = AGENTS_PTR_SIZE'(p);
        end
    end
  end

  always_comb begin
    read_o = '0;
    if (rst_n)
      for (int p = 0; p < PORT_NUM; p++)
        read_o[p] = s1_gnt[p] & {VC_NUM{in_won[p]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= '0;
      xbar_sel_o <= '0;
    end else begin
      valid_o <= out_gnt;
      for (int o = 0; o < PORT_NUM; o++)
        if (out_gnt[o]) xbar_sel_o[o] <= sel_nxt[o];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed table-driven bench for switch_allocator; expectations follow SA_ON_OFF_GATING_EN.
module tb_switch_allocator;
  import noc_params::*;

  localparam int SELW = $clog2(PORT_NUM);
  localparam int PW   = $bits(port_t);

  typedef struct {
    logic [PORT_NUM-1:0][VC_NUM-1:0]              req;
    logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0]      op;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
    logic [PORT_NUM-1:0][VC_NUM-1:0]              onoff;
    logic [PORT_NUM-1:0][VC_NUM-1:0]              exp_read;
    logic [PORT_NUM-1:0]                          exp_valid;
    logic [PORT_NUM-1:0][SELW-1:0]                exp_sel;
  } vec_t;

  logic                                         clk;
  logic                                         rst_n;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]             request_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]             out_port_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]             on_off_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]             read_o;
  logic  [PORT_NUM-1:0][SELW-1:0]               xbar_sel_o;
  logic  [PORT_NUM-1:0]                         valid_o;

  int   checks = 0;
  int   errors = 0;
  vec_t cur;
  vec_t tbl[$];

  switch_allocator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .request_i       (request_i),
    .out_port_i      (out_port_i),
    .downstream_vc_i (downstream_vc_i),
    .on_off_i        (on_off_i),
    .read_o          (read_o),
    .xbar_sel_o      (xbar_sel_o),
    .valid_o         (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void clr();
    cur.req       = '0;
    cur.op        = '0;
    cur.dvc       = '0;
    cur.onoff     = '1;
    cur.exp_read  = '0;
    cur.exp_valid = '0;
    cur.exp_sel   = '0;
  endfunction

  function automatic void rq(input int p, input int v, input port_t o, input int d = 0);
    cur.req[p][v] = 1'b1;
    cur.op[p][v]  = o;
    cur.dvc[p][v] = VC_SIZE'(d);
  endfunction

  function automatic void gr(input int p, input int v, input port_t o);
    cur.exp_read[p][v] = 1'b1;
    cur.exp_valid[o]   = 1'b1;
    cur.exp_sel[o]     = SELW'(p);
  endfunction

  task automatic drive(input vec_t t);
    request_i       = t.req;
    downstream_vc_i = t.dvc;
    on_off_i        = t.onoff;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        out_port_i[p][v] = port_t'(t.op[p][v]);
  endtask

  task automatic check_read(input string nm, input vec_t t);
    chk({nm, " read_o"}, 64'(read_o), 64'(t.exp_read));
  endtask

  task automatic check_out(input string nm, input vec_t t);
    chk({nm, " valid_o"}, 64'(valid_o), 64'(t.exp_valid));
    for (int o = 0; o < PORT_NUM; o++)
      if (t.exp_valid[o])
        chk($sformatf("%s xbar_sel[%0d]", nm, o), 64'(xbar_sel_o[o]), 64'(t.exp_sel[o]));
  endtask

  // entered at posedge+1: inputs settle, read_o sampled before the edge, registered outputs after
  task automatic run_vec(input string nm, input vec_t t);
    drive(t);
    #4;
    check_read(nm, t);
    @(posedge clk);
    #1;
    check_out(nm, t);
  endtask

  initial begin
    // single requester, EAST
    clr(); rq(0, 0, EAST); gr(0, 0, EAST); tbl.push_back(cur);
    // inputs 1 and 3 contend for NORTH: 1,3,1,3
    clr(); rq(1, 0, NORTH); rq(3, 0, NORTH); gr(1, 0, NORTH); tbl.push_back(cur);
    clr(); rq(1, 0, NORTH); rq(3, 0, NORTH); gr(3, 0, NORTH); tbl.push_back(cur);
    clr(); rq(1, 0, NORTH); rq(3, 0, NORTH); gr(1, 0, NORTH); tbl.push_back(cur);
    clr(); rq(1, 0, NORTH); rq(3, 0, NORTH); gr(3, 0, NORTH); tbl.push_back(cur);
    // input 2 VC0->SOUTH, VC1->WEST alternate
    clr(); rq(2, 0, SOUTH); rq(2, 1, WEST); gr(2, 0, SOUTH); tbl.push_back(cur);
    clr(); rq(2, 0, SOUTH); rq(2, 1, WEST); gr(2, 1, WEST);  tbl.push_back(cur);
    clr(); rq(2, 0, SOUTH); rq(2, 1, WEST); gr(2, 0, SOUTH); tbl.push_back(cur);
    clr(); rq(2, 0, SOUTH); rq(2, 1, WEST); gr(2, 1, WEST);  tbl.push_back(cur);
    // downstream SOUTH VC1 switched off, then back on
    clr(); rq(0, 0, SOUTH, 1); cur.onoff[SOUTH][1] = 1'b0;
`ifndef SA_ON_OFF_GATING_EN
    gr(0, 0, SOUTH);
`endif
    tbl.push_back(cur);
    clr(); rq(0, 0, SOUTH, 1); gr(0, 0, SOUTH); tbl.push_back(cur);
    // idle cycle
    clr(); tbl.push_back(cur);
    // input 4 loses EAST to input 3, then re-offers VC0; then VC1 wraps its pointer
    clr(); rq(3, 0, EAST); rq(4, 0, EAST); rq(4, 1, LOCAL); gr(3, 0, EAST); tbl.push_back(cur);
    clr(); rq(3, 0, EAST); rq(4, 0, EAST); rq(4, 1, LOCAL); gr(4, 0, EAST); tbl.push_back(cur);
    clr(); rq(3, 0, EAST); rq(4, 0, EAST); rq(4, 1, LOCAL); gr(3, 0, EAST); gr(4, 1, LOCAL);
    tbl.push_back(cur);

    rst_n = 1'b0;
    clr(); drive(cur);
    #12;
    chk("reset valid_o", 64'(valid_o), 64'd0);
    chk("reset xbar_sel_o", 64'(xbar_sel_o), 64'd0);
    clr(); rq(0, 0, EAST); drive(cur);
    #1;
    chk("reset read_o", 64'(read_o), 64'd0);
    clr(); drive(cur);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // asynchronous reset while WEST is valid
    clr(); rq(1, 0, WEST); gr(1, 0, WEST);
    run_vec("pre-reset", cur);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-reset valid_o", 64'(valid_o), 64'd0);
    chk("mid-reset xbar_sel_o", 64'(xbar_sel_o), 64'd0);
    chk("mid-reset read_o", 64'(read_o), 64'd0);
    clr(); rq(1, 0, WEST); rq(3, 0, WEST); gr(1, 0, WEST);
    drive(cur);
    #2 rst_n = 1'b1;
    #4;
    check_read("post-reset0", cur);
    @(posedge clk);
    #1;
    check_out("post-reset0", cur);
    clr(); rq(1, 0, WEST); rq(3, 0, WEST); gr(3, 0, WEST);
    run_vec("post-reset1", cur);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter AGENTS_PTR_SIZE, default $clog2(PORT_NUM), meaning the input-port index width for crossbar select.
REQ-002 SHALL have port clk  input  1  meaning the single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-004 SHALL have port request_i  input  [PORT_NUM][VC_NUM]  meaning per input VC, switch request (SA state).
REQ-005 SHALL have port out_port_i  input  port_t [PORT_NUM][VC_NUM]  meaning per input VC, next-hop output port.
REQ-006 SHALL have port downstream_vc_i  input  [PORT_NUM][VC_NUM][VC_SIZE]  meaning per input VC, allocated downstream VC.
REQ-007 SHALL have port on_off_i  input  [PORT_NUM][VC_NUM]  meaning per output port and downstream VC, 1 = downstream may accept.
REQ-008 SHALL have port read_o  input-VC-indexed output  [PORT_NUM][VC_NUM]  meaning combinational grant, same-cycle read strobe to input buffer.
REQ-009 SHALL have port xbar_sel_o  output  [PORT_NUM][AGENTS_PTR_SIZE]  meaning registered, per output port, winning input port.
REQ-010 SHALL have port valid_o  output  [PORT_NUM]  meaning registered, per output port, flit traverses crossbar this cycle.

Function
REQ-011 SHALL be separable input-first: stage 1 per input port picks one eligible VC round-robin; stage 2 per output port picks one stage-1 winner round-robin.
REQ-012 SHALL treat VC v of input p as eligible iff request_i[p][v]=1 and on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]]=1.
REQ-013 SHALL compute read_o combinationally in the same cycle; read_o[p] is zero or one-hot; at most one input granted per output port.
REQ-014 SHALL register xbar_sel_o[o] and valid_o[o] on the edge after the grant (switch traversal latency 1 cycle); valid_o[o]=0 when no grant.
REQ-015 SHALL advance an output-stage pointer to one past the winner only on a grant; stage-1 pointer of port p advances past its winner only if that winner also wins stage 2.
REQ-016 SHALL hold all pointers when no eligible request exists; pointer wrap-around from N-1 to 0.
REQ-017 SHALL grant a single eligible requester in the same cycle it requests, regardless of pointer position.
REQ-018 SHALL, on request_i deasserted for a VC, exclude it that cycle; no grant is held across cycles.

Reset
REQ-019 SHALL, while rst_n=0, clear all pointers to 0, xbar_sel_o to 0, valid_o to 0; read_o evaluates to 0 regardless of inputs.
REQ-020 SHALL, on reset asserted mid-operation, drop in-flight valid_o immediately (asynchronous) and resume arbitration from pointer 0 after deassertion.

Configuration
REQ-021 SHALL, with SA_ON_OFF_GATING_EN defined, apply the on_off_i term of REQ-012.
REQ-022 SHALL, without SA_ON_OFF_GATING_EN, ignore on_off_i (eligibility = request_i only), all other behaviour unchanged.

Structure
REQ-023 SHALL take PORT_NUM, VC_NUM, VC_SIZE, port_t from package noc_params; no new constants local to the module.
REQ-024 SHALL instantiate sub-module round_robin_arbiter #(AGENTS_NUM) for every stage-1 and stage-2 arbiter (request vector in, one-hot grant out, internal pointer, update-enable input).

Verification (PORT_NUM=5, VC_NUM=2, gating enabled)
REQ-025 SHALL cover: after reset, request_i[0][0]=1 to EAST, on_off ok -> read_o[0]=2'b01 same cycle; next cycle valid_o[EAST]=1, xbar_sel_o[EAST]=0.
REQ-026 SHALL cover: inputs 1 and 3 both request NORTH continuously for 4 cycles -> grants alternate 1,3,1,3; one read per cycle.
REQ-027 SHALL cover: input 2 VC0 and VC1 both request, distinct outputs -> grants alternate VC0,VC1; never both in one cycle.
REQ-028 SHALL cover: on_off_i[SOUTH][1]=0, request targets SOUTH VC1 -> read_o=0, valid_o[SOUTH]=0; on_off raised -> grant same cycle.
REQ-029 SHALL cover: rst_n pulled low while valid_o[WEST]=1 -> valid_o=0 immediately; after release, contention resolves starting from index 0.
REQ-030 SHALL cover: stage-1 winner of input 4 loses stage 2 -> input 4 pointer unchanged, same VC re-offered next cycle.
